// File: rtl/xseq_player.sv
// Memory-game sequence presenter: reads symbols from a sync-read RAM and
// flashes each one on a one-hot LED bus, paced by an external interval timer.
module xseq_player #(
  parameter int SYM_W = 2,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      len,
  output logic [LEN_W-1:0]      mem_addr,
  input  logic [SYM_W-1:0]      mem_rdata,
  output logic [2**SYM_W-1:0]   led,
  output logic                  tmr_en,
  input  logic                  tmr_tc,
  output logic                  busy,
  output logic                  done
);

  localparam int LED_W = 2**SYM_W;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHOW, S_GAP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [LEN_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               tmr_en_q, tmr_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic [LED_W-1:0] onehot(input logic [SYM_W-1:0] s);
    onehot = '0;
    onehot[s] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sym_q      <= '0;
      mem_addr_q <= '0;
      led_q      <= '0;
      cnt_q      <= '0;
      tmr_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      mem_addr_q <= mem_addr_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      tmr_en_q   <= tmr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

  // cnt_q counts cycles since the last timer restart, saturating at GUARD;
  // tmr_tc is only trusted once it reaches GUARD, masking a stale count.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    sym_d      = sym_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = (cnt_q == GUARD) ? GUARD : cnt_q + 2'd1;
    led_d      = '0;
    tmr_en_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d      = len;
            idx_d      = '0;
            mem_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sym_d    = mem_rdata;
        led_d    = onehot(mem_rdata);
        tmr_en_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        led_d = onehot(sym_q);
        if (cnt_q == GUARD && tmr_tc) begin
          led_d    = '0;
          tmr_en_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GUARD && tmr_tc) begin
          if (idx_q == len_q - ONE) begin
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + ONE;
            mem_addr_d = idx_q + ONE;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      idx_d      = idx_q;
      mem_addr_d = mem_addr_q;
      led_d      = '0;
      tmr_en_d   = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign mem_addr = mem_addr_q;
  assign led      = led_q;
  assign tmr_en   = tmr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_xseq_player.sv
// Scoreboard bench for xseq_player: RAM and interval-timer models, expected
// LED/address per timer restart queued at start and compared on each pulse.
module tb_xseq_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] len = '0;
  logic [3:0] mem_addr;
  logic [1:0] mem_rdata = '0;
  logic [3:0] led;
  logic       tmr_en;
  logic       tmr_tc = 1'b0;
  logic       busy;
  logic       done;

  xseq_player #(.SYM_W(2), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .led(led),
    .tmr_en(tmr_en), .tmr_tc(tmr_tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] led;
    logic [3:0] addr;
    int         dt;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] ram [16];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         last_pulse_cyc = 0;
  int         n_pulse = 0;
  int         n_done = 0;
  int         tcnt = 0;
  bit         stale = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] s);
    oh = 4'b0001 << s;
  endfunction

  // Sync-read RAM and interval timer (tc rises 5 cycles after a restart).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= ram[mem_addr];
    if (tmr_en) begin
      tcnt <= 1;
      if (!stale) tmr_tc <= 1'b0;
    end else if (tcnt != 0 && tcnt < 5) begin
      tcnt <= tcnt + 1;
      if (tcnt == 1) tmr_tc <= 1'b0;
      if (tcnt == 4) tmr_tc <= 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done) n_done++;
    if (tmr_en) begin
      n_pulse++;
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_val("led", int'(led), int'(e.led));
        check_val("addr", int'(mem_addr), int'(e.addr));
        if (e.dt != 0) check_val("phase_len", cyc - last_pulse_cyc, e.dt);
      end
      last_pulse_cyc = cyc;
    end
  end

  task automatic push_play(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{oh(ram[i]), 4'(i), (i == 0) ? 0 : 8});
      sb_q.push_back('{4'b0000, 4'(i), 6});
    end
  endtask

  task automatic do_start(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = 4'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == max_cyc) check_val("timeout_done", int'(done), 1);
  endtask

  task automatic wait_pulse(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (tmr_en) break;
    end
    if (k == max_cyc) check_val("timeout_pulse", int'(tmr_en), 1);
  endtask

  task automatic play_and_check(input int l, input string tag);
    int p0, d0;
    p0 = n_pulse;
    d0 = n_done;
    push_play(l);
    do_start(l);
    wait_done(2000);
    check_val({tag, "_done_gap"}, cyc - last_pulse_cyc, 6);
    check_val({tag, "_busy_at_done"}, int'(busy), 1);
    @(negedge clk);
    check_val({tag, "_busy_after"}, int'(busy), 0);
    check_val({tag, "_done_after"}, int'(done), 0);
    check_val({tag, "_pulses"}, n_pulse - p0, 2 * l);
    check_val({tag, "_done_cnt"}, n_done - d0, 1);
    check_val({tag, "_sb_left"}, sb_q.size(), 0);
  endtask

  initial begin
    int p0, d0;
    logic [3:0] a0;
    for (int i = 0; i < 16; i++) ram[i] = 2'(i * 3 + 1);
    ram[0] = 2'd2;
    ram[1] = 2'd0;
    ram[2] = 2'd3;

    repeat (3) @(negedge clk);
    check_val("rst_led", int'(led), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_tmr_en", int'(tmr_en), 0);
    check_val("rst_addr", int'(mem_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic playback of {2,0,3}
    play_and_check(3, "basic");

    // Zero length: immediate done, no RAM or timer activity
    p0 = n_pulse;
    a0 = mem_addr;
    do_start(0);
    check_val("len0_done", int'(done), 1);
    @(negedge clk);
    check_val("len0_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    check_val("len0_pulses", n_pulse - p0, 0);
    check_val("len0_addr", int'(mem_addr), int'(a0));

    // Stale terminal count held across restart
    stale = 1'b1;
    play_and_check(2, "stale");
    stale = 1'b0;

    // Abort in third SHOW cycle of the first symbol
    d0 = n_done;
    push_play(3);
    do_start(3);
    wait_pulse(50);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_led", int'(led), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_tmr_en", int'(tmr_en), 0);
    sb_q.delete();
    repeat (10) @(negedge clk);
    check_val("abort_no_done", n_done - d0, 0);
    play_and_check(1, "replay");

    // Reset mid-GAP, with an ignored start issued while busy
    d0 = n_done;
    push_play(3);
    do_start(3);
    wait_pulse(50);
    @(negedge clk);
    start = 1'b1;
    len   = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_pulse(50);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mrst_led", int'(led), 0);
    check_val("mrst_busy", int'(busy), 0);
    check_val("mrst_done", int'(done), 0);
    check_val("mrst_tmr_en", int'(tmr_en), 0);
    check_val("mrst_addr", int'(mem_addr), 0);
    sb_q.delete();
    repeat (10) @(negedge clk);
    check_val("mrst_no_done", n_done - d0, 0);
    play_and_check(2, "post_rst");

    // Maximum length walks addresses 0..14
    play_and_check(15, "maxlen");
    check_val("maxlen_last_addr", int'(mem_addr), 14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
